// File: rtl/corr_best_match.sv
// Raster-order sweep controller for the correlator window origin.
// Tracks the lowest score seen during the sweep and the origin that produced it.
module corr_best_match #(
  parameter int SCORE_W       = 20,
  parameter int STEP          = 1,
  parameter bit DISCARD_FIRST = 1'b1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [12:0]        iX_min,
  input  logic [12:0]        iX_max,
  input  logic [12:0]        iY_min,
  input  logic [12:0]        iY_max,
  input  logic               iCorr_finished,
  input  logic [SCORE_W-1:0] iCorr_score,
  output logic [12:0]        oXstart,
  output logic [12:0]        oYstart,
  output logic [12:0]        oBest_x,
  output logic [12:0]        oBest_y,
  output logic [SCORE_W-1:0] oBest_score,
  output logic               oBusy,
  output logic               oDone,
  output logic [15:0]        oCount
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

  localparam logic [13:0] STEP14 = 14'(STEP);

  state_e             state_q, state_d;
  logic [12:0]        xMin_q, xMin_d, xMax_q, xMax_d;
  logic [12:0]        yMin_q, yMin_d, yMax_q, yMax_d;
  logic               degen_q, degen_d;
  logic [12:0]        xStart_q, xStart_d, yStart_q, yStart_d;
  logic [12:0]        bestX_q, bestX_d, bestY_q, bestY_d;
  logic [SCORE_W-1:0] bestScore_q, bestScore_d;
  logic [15:0]        count_q, count_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [13:0]        xSum, ySum;

  // 14-bit sums so an origin near 8191 cannot wrap past the rectangle edge.
  assign xSum = {1'b0, xStart_q} + STEP14;
  assign ySum = {1'b0, yStart_q} + STEP14;

  always_comb begin
    state_d     = state_q;
    xMin_d      = xMin_q;
    xMax_d      = xMax_q;
    yMin_d      = yMin_q;
    yMax_d      = yMax_q;
    degen_d     = degen_q;
    xStart_d    = xStart_q;
    yStart_d    = yStart_q;
    bestX_d     = bestX_q;
    bestY_d     = bestY_q;
    bestScore_d = bestScore_q;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          xMin_d      = iX_min;
          xMax_d      = iX_max;
          yMin_d      = iY_min;
          yMax_d      = iY_max;
          degen_d     = (iX_min > iX_max) || (iY_min > iY_max);
          xStart_d    = iX_min;
          yStart_d    = iY_min;
          bestX_d     = iX_min;
          bestY_d     = iY_min;
          bestScore_d = '1;
          count_d     = '0;
          state_d     = DISCARD_FIRST ? ARM : RUN;
        end
      end
      ARM: begin
        if (iAbort) state_d = IDLE;
        else if (iCorr_finished) state_d = RUN;
      end
      RUN: begin
        if (iAbort) begin
          state_d = IDLE;
        end else if (iCorr_finished) begin
          if (iCorr_score < bestScore_q) begin
            bestScore_d = iCorr_score;
            bestX_d     = xStart_q;
            bestY_d     = yStart_q;
          end
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          // A degenerate rectangle scores only its first window.
          if (degen_q) begin
            state_d = DONE;
          end else if (xSum <= {1'b0, xMax_q}) begin
            xStart_d = xSum[12:0];
          end else if (ySum <= {1'b0, yMax_q}) begin
            xStart_d = xMin_q;
            yStart_d = ySum[12:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARM) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      xMin_q      <= '0;
      xMax_q      <= '0;
      yMin_q      <= '0;
      yMax_q      <= '0;
      degen_q     <= 1'b0;
      xStart_q    <= '0;
      yStart_q    <= '0;
      bestX_q     <= '0;
      bestY_q     <= '0;
      bestScore_q <= '1;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xMin_q      <= xMin_d;
      xMax_q      <= xMax_d;
      yMin_q      <= yMin_d;
      yMax_q      <= yMax_d;
      degen_q     <= degen_d;
      xStart_q    <= xStart_d;
      yStart_q    <= yStart_d;
      bestX_q     <= bestX_d;
      bestY_q     <= bestY_d;
      bestScore_q <= bestScore_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign oXstart     = xStart_q;
  assign oYstart     = yStart_q;
  assign oBest_x     = bestX_q;
  assign oBest_y     = bestY_q;
  assign oBest_score = bestScore_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oCount      = count_q;

endmodule

// File: doc/corr_best_match.md
# corr_best_match

Sweep controller and best-match tracker placed directly downstream of the correlation-score stage. It drives the correlator's window origin (Xstart/Ystart) in raster order over a programmed search rectangle. On each correlator finish pulse it captures the score and keeps the minimum score with its origin. It reports the winning position when the sweep completes.

## Interface
- SCORE_W, 20: width of correlator score and best-score register.
- STEP, 1: origin increment in X and in Y, in pixels, range 1..15.
- DISCARD_FIRST, 1: when 1, the first iCorr_finished after iStart is dropped because its window began before the new origin was loaded.

Ports:
- iCLK  in  1  system clock; all state on rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse; begins a sweep; honoured only in IDLE.
- iAbort  in  1  returns to IDLE from any state; best registers keep their values.
- iX_min, iX_max, iY_min, iY_max  in  13 each  search rectangle, inclusive; latched on accepted iStart.
- iCorr_finished  in  1  one-cycle pulse from correlator; window score valid this cycle.
- iCorr_score  in  SCORE_W  correlator score, unsigned; lower is better.
- oXstart, oYstart  out  13  window origin fed to correlator.
- oBest_x, oBest_y  out  13  origin of the best window so far.
- oBest_score  out  SCORE_W  best score so far.
- oBusy  out  1  high in ARM and RUN.
- oDone  out  1  one-cycle pulse when the sweep completes normally.
- oCount  out  16  windows scored in the current or last sweep; saturates at 0xFFFF.

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE: iCorr_finished is ignored. On iStart:
  - latch the rectangle;
  - set oXstart=iX_min and oYstart=iY_min;
  - set oBest_score to all ones, oBest_x=iX_min, oBest_y=iY_min, oCount=0;
  - go to ARM if DISCARD_FIRST=1, otherwise RUN.
- ARM: the first iCorr_finished is discarded, with no compare, no advance and no count. Go to RUN.
- RUN: on iCorr_finished:
  - if iCorr_score < oBest_score (strict), load the score and the current oXstart/oYstart into the best registers. Ties keep the earlier window.
  - increment oCount.
  - Advance rule, with sums computed at 14 bits so there is no 13-bit wrap: if oXstart+STEP <= X_max, X += STEP. Else X = X_min and, if oYstart+STEP <= Y_max, Y += STEP. Otherwise go to DONE with the origin unchanged.
- DONE: assert oDone for one cycle, then IDLE. The best registers and oCount hold until the next accepted iStart.
- Degenerate rectangle: if latched X_min > X_max, or Y_min > Y_max, exactly one window is scored at (X_min, Y_min), then DONE.
- iAbort has priority over every other event in the same cycle. In IDLE it has no effect. oDone is not asserted on abort.
- iStart outside IDLE is ignored.
- iCorr_finished coincident with iStart in IDLE is ignored.

## Timing
- Reset values: state IDLE; oXstart=oYstart=0, oBest_x=oBest_y=0, oBest_score all ones, oBusy=0, oDone=0, oCount=0.
- Reset mid-sweep clears everything to the reset values immediately; no oDone.
- All outputs are registered.
- The origin update is visible on the edge after iCorr_finished; the correlator starts its next window from that value.
- Best-register update happens on the same edge as the origin advance. A finish in cycle N is reflected in oBest_* from cycle N+1.
- oDone rises on the edge that enters DONE, which is 1 cycle after the last finish is captured. It lasts exactly 1 cycle, and oBusy falls together with it.
- Throughput: one window per finish pulse; back-to-back finish pulses in consecutive cycles are each handled.
- The compare is combinational on iCorr_score in the finish cycle; the score is not registered beforehand.

## Test plan
- Basic sweep: STEP=1, DISCARD_FIRST=0, rect X 0..2, Y 0..1, scores 9,7,8,7,5,6 in raster order.
  - oXstart/oYstart step (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - oBest=(1,1), score 5; oCount=6; one oDone pulse.
- Discard and ties: DISCARD_FIRST=1, rect 4..4 x 10..11, STEP=1; finish scores 0 (dropped), 3, 3.
  - oCount=2; best=(4,10), score 3.
- Step and wrap: STEP=4, X 0..9, Y 0..4.
  - Origins are 0,4,8 on Y=0 and 0,4,8 on Y=4, then DONE; X never exceeds 9.
  - X_max=8191 with STEP=4 and X=8188 wraps cleanly.
- Degenerate rectangle: X_min=5, X_max=3; one finish, score 12 -> best=(5,Y_min), score 12, oCount=1, oDone.
- Abort and reset: abort after 2 windows -> IDLE, no oDone, best retained.
  - iStart while busy is ignored.
  - iRST mid-RUN -> all outputs at reset values within the same cycle.
- Simultaneous events: iAbort with iCorr_finished -> no compare and no count.
  - Finish pulses in IDLE leave every output unchanged.
